// File: rtl/ir_cmd_scheduler_if.sv
// rtl/ir_cmd_scheduler_if.sv - handshake bundle between the command scheduler and the IR frame transmitter
interface ir_cmd_scheduler_if;
    logic        tx_start;
    logic        tx_busy;
    logic [34:0] tx_data35;
    logic [31:0] tx_data32;

    modport master (output tx_start, output tx_data35, output tx_data32, input tx_busy);
    modport slave  (input tx_start, input tx_data35, input tx_data32, output tx_busy);
endinterface

// File: rtl/ir_cmd_scheduler.sv
// rtl/ir_cmd_scheduler.sv - air-conditioner settings owner and IR command frame scheduler
module ir_cmd_scheduler #(
    parameter logic [22:0] HDR35       = 23'h041008,
    parameter logic [27:0] HDR32       = 28'h0080400,
    parameter int          TEMP_MIN    = 16,
    parameter int          TEMP_MAX    = 30,
    parameter int          TEMP_RESET  = 25,
    parameter int          MODE_MAX    = 4,
    parameter int          GAP_CYCLES  = 12500000,
    parameter int          ACK_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      btn_power,
    input  logic                      btn_mode,
    input  logic                      btn_fan,
    input  logic                      btn_temp_up,
    input  logic                      btn_temp_down,
    ir_cmd_scheduler_if.master        tx,
    output logic                      power_on,
    output logic [2:0]                mode_out,
    output logic [1:0]                fan_out,
    output logic [4:0]                temp_out,
    output logic                      pending,
    output logic                      err_timeout,
    output logic [7:0]                frame_cnt
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t      state, state_d;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [34:0] data35;
    logic [31:0] data32;

    logic        en;
    logic        power_d;
    logic [2:0]  mode_d;
    logic [1:0]  fan_d;
    logic [4:0]  temp_d;
    logic        changed;
    logic        pending_d;
    logic [3:0]  tc;
    logic [3:0]  chk;
    logic        start;
    logic        err;

    // Non-power buttons only act while the unit is on and power is not flipping this cycle.
    always_comb begin
        en      = power_on & ~btn_power;
        power_d = power_on ^ btn_power;
        mode_d  = mode_out;
        fan_d   = fan_out;
        temp_d  = temp_out;
        if (en && btn_mode)
            mode_d = (mode_out == 3'(MODE_MAX)) ? 3'd0 : mode_out + 3'd1;
        if (en && btn_fan)
            fan_d = fan_out + 2'd1;
        if (en && btn_temp_up && !btn_temp_down && (temp_out < 5'(TEMP_MAX)))
            temp_d = temp_out + 5'd1;
        if (en && btn_temp_down && !btn_temp_up && (temp_out > 5'(TEMP_MIN)))
            temp_d = temp_out - 5'd1;
        changed   = btn_power | (mode_d != mode_out) | (fan_d != fan_out) | (temp_d != temp_out);
        // A change in the LOAD cycle must survive the clear so it gets its own frame.
        pending_d = changed | (pending & (state != LOAD));
    end

    always_comb begin
        tc  = 4'(temp_out - 5'(TEMP_MIN));
        chk = {1'b0, mode_out} + tc + {2'b00, fan_out} + {3'b000, power_on};
    end

    always_comb begin
        state_d = state;
        start   = 1'b0;
        err     = 1'b0;
        case (state)
            IDLE:      if (pending_d) state_d = LOAD;
            LOAD:      state_d = START;
            START: begin
                if (!tx.tx_busy) begin
                    start   = 1'b1;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    err     = 1'b1;
                    state_d = GAP;
                end
            end
            WAIT_DONE: if (!tx.tx_busy) state_d = GAP;
            GAP:       if (gap_cnt == GW'(GAP_CYCLES - 1)) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            power_on  <= 1'b0;
            mode_out  <= 3'd0;
            fan_out   <= 2'd0;
            temp_out  <= 5'(TEMP_RESET);
            pending   <= 1'b0;
            data35    <= '0;
            data32    <= '0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
            frame_cnt <= 8'd0;
        end else begin
            state    <= state_d;
            power_on <= power_d;
            mode_out <= mode_d;
            fan_out  <= fan_d;
            temp_out <= temp_d;
            pending  <= pending_d;
            if (state == LOAD) begin
                data35 <= {HDR35, tc, fan_out, 1'b0, power_on, 1'b0, mode_out};
                data32 <= {HDR32, chk};
            end
            if (state == START)
                tmo_cnt <= '0;
            else if (state == WAIT_BUSY)
                tmo_cnt <= tmo_cnt + 1'b1;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (state == WAIT_DONE && !tx.tx_busy)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign tx.tx_start  = start;
    assign tx.tx_data35 = data35;
    assign tx.tx_data32 = data32;
    assign err_timeout  = err;

endmodule
